// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle execute-stage ALU.
//   - alu_op_e     : operation codes presented on Operation
//   - alu_state_e  : control FSM states of alu_mc
//   - DIV_BY_ZERO_Q: quotient returned for an unsigned divide by zero
//                    (all ones; sliced to DATA_WIDTH by the user, which
//                    bounds DATA_WIDTH to MAX_W)
package alu_pkg;

  localparam int OP_W  = 4;
  localparam int MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SLT   = 4'b0100,
    OP_SLTU  = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLL   = 4'b0111,
    OP_EQ    = 4'b1000,
    OP_SRL   = 4'b1001,
    OP_SRA   = 4'b1010,
    OP_MUL   = 4'b1011,
    OP_MULHU = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REMU  = 4'b1110,
    OP_NONE  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

  localparam logic [MAX_W-1:0] DIV_BY_ZERO_Q = {MAX_W{1'b1}};

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative unsigned multiply / restoring divide, one step per
// clock over W cycles.
//   clk, reset (async, active-high), flush (abort current operation)
//   start   : load a/b and begin (ignored while flush is high)
//   is_div  : 1 = divide a/b, 0 = multiply a*b
//   a, b    : operands, sampled on start
//   lo, hi  : accumulator value *after* the step taken this cycle;
//             multiply -> {hi,lo} = product, divide -> lo = quotient,
//             hi = remainder. Valid as a final result when done=1.
//   busy    : an operation is in progress
//   done    : this cycle performs the last step (busy && counter == 0)
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         busy,
  output logic         done
);

  logic [2*W-1:0] acc;
  logic [W-1:0]   operand_b;
  logic [W-1:0]   count;
  logic           mode_div;

  logic [W:0]     add_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_shift;
  logic [W:0]     sub_diff;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] acc_next;

  // One shift-add or restoring-divide step on the current accumulator.
  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}. Add the
    // multiplicand into the upper half when the current multiplier bit is
    // set, then shift right keeping the carry.
    add_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, operand_b};
    if (acc[0]) begin
      mul_next = {add_sum, acc[W-1:1]};
    end else begin
      mul_next = {1'b0, acc[2*W-1:W], acc[W-1:1]};
    end
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    // Shift the next dividend bit into the remainder; subtract when it fits
    // (no borrow) and shift the quotient bit in at the bottom.
    rem_shift = {acc[2*W-1:W], acc[W-1]};
    sub_diff  = rem_shift - {1'b0, operand_b};
    if (sub_diff[W]) begin
      div_next = {rem_shift[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      div_next = {sub_diff[W-1:0], acc[W-2:0], 1'b1};
    end
    if (mode_div) begin
      acc_next = div_next;
    end else begin
      acc_next = mul_next;
    end
  end

  assign lo   = acc_next[W-1:0];
  assign hi   = acc_next[2*W-1:W];
  assign done = busy && (count == {W{1'b0}});

  // Operand load, per-cycle iteration and step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= {(2*W){1'b0}};
      operand_b <= {W{1'b0}};
      count     <= {W{1'b0}};
      mode_div  <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (start) begin
      acc       <= {{W{1'b0}}, a};
      operand_b <= b;
      count     <= W'(W - 1);
      mode_div  <= is_div;
      busy      <= 1'b1;
    end else if (busy) begin
      acc   <= acc_next;
      count <= count - {{(W-1){1'b0}}, 1'b1};
      if (count == {W{1'b0}}) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready handshake.
// Single-cycle integer ops produce a registered result one cycle after
// accept; MUL/MULHU/DIVU/REMU iterate for DATA_WIDTH cycles in muldiv_iter.
//   clk, reset      : clock (rising edge), async active-high reset
//   flush           : abandon in-flight/pending op, return to IDLE
//   in_valid/in_ready, SrcA, SrcB, Operation : request side
//   out_valid/out_ready, ALUResult, Zero     : response side; ALUResult and
//                     Zero are held stable while out_valid && !out_ready
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  alu_state_e                 state;
  logic [OPCODE_LENGTH-1:0]   op_q;

  logic                       accept;
  logic                       op_is_mul;
  logic                       op_is_div;
  logic                       divisor_zero;
  logic                       launch_iter;
  logic [SH_W-1:0]            shamt;
  logic [DATA_WIDTH-1:0]      single_result;
  logic [DATA_WIDTH-1:0]      launch_result;
  logic [DATA_WIDTH-1:0]      iter_result;

  logic [DATA_WIDTH-1:0]      iter_lo;
  logic [DATA_WIDTH-1:0]      iter_hi;
  logic                       iter_busy;
  logic                       iter_done;

  function automatic logic is_zero(input logic [DATA_WIDTH-1:0] v);
    return (v == {DATA_WIDTH{1'b0}});
  endfunction

  assign in_ready     = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept       = in_valid && in_ready && !flush;
  assign shamt        = SrcB[SH_W-1:0];
  assign divisor_zero = is_zero(SrcB);
  // Divide by zero is answered immediately, so it never starts the iterator.
  assign launch_iter  = op_is_mul || (op_is_div && !divisor_zero);

  // Opcode decode and single-cycle result computation.
  always_comb begin
    op_is_mul     = 1'b0;
    op_is_div     = 1'b0;
    single_result = {DATA_WIDTH{1'b0}};
    case (Operation)
      OPCODE_LENGTH'(OP_AND):  single_result = SrcA & SrcB;
      OPCODE_LENGTH'(OP_OR):   single_result = SrcA | SrcB;
      OPCODE_LENGTH'(OP_ADD):  single_result = SrcA + SrcB;
      OPCODE_LENGTH'(OP_XOR):  single_result = SrcA ^ SrcB;
      OPCODE_LENGTH'(OP_SLT):
        single_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OPCODE_LENGTH'(OP_SLTU):
        single_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OPCODE_LENGTH'(OP_SUB):  single_result = SrcA - SrcB;
      OPCODE_LENGTH'(OP_SLL):  single_result = SrcA << shamt;
      OPCODE_LENGTH'(OP_EQ):
        single_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OPCODE_LENGTH'(OP_SRL):  single_result = SrcA >> shamt;
      OPCODE_LENGTH'(OP_SRA):  single_result = DATA_WIDTH'($signed(SrcA) >>> shamt);
      OPCODE_LENGTH'(OP_MUL), OPCODE_LENGTH'(OP_MULHU): op_is_mul = 1'b1;
      OPCODE_LENGTH'(OP_DIVU), OPCODE_LENGTH'(OP_REMU): op_is_div = 1'b1;
      default: single_result = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Result registered at accept: single-cycle value or divide-by-zero answer.
  always_comb begin
    if (op_is_div && divisor_zero) begin
      if (Operation == OPCODE_LENGTH'(OP_REMU)) begin
        launch_result = SrcA;
      end else begin
        launch_result = DIV_BY_ZERO_Q[DATA_WIDTH-1:0];
      end
    end else begin
      launch_result = single_result;
    end
  end

  // Select the iterator half that holds the answer for the captured opcode.
  always_comb begin
    case (op_q)
      OPCODE_LENGTH'(OP_MULHU), OPCODE_LENGTH'(OP_REMU): iter_result = iter_hi;
      default:                                           iter_result = iter_lo;
    endcase
  end

  muldiv_iter #(
    .W(DATA_WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .start  (accept && launch_iter),
    .is_div (op_is_div),
    .a      (SrcA),
    .b      (SrcB),
    .lo     (iter_lo),
    .hi     (iter_hi),
    .busy   (iter_busy),
    .done   (iter_done)
  );

  // Control FSM and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= {OPCODE_LENGTH{1'b0}};
      out_valid <= 1'b0;
      ALUResult <= {DATA_WIDTH{1'b0}};
      Zero      <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      ALUResult <= {DATA_WIDTH{1'b0}};
      Zero      <= 1'b0;
    end else if (accept) begin
      // Accept happens from IDLE or, back-to-back, from a consumed DONE.
      op_q <= Operation;
      if (launch_iter) begin
        state     <= op_is_div ? ST_DIV : ST_MUL;
        out_valid <= 1'b0;
        Zero      <= 1'b0;
      end else begin
        state     <= ST_DONE;
        out_valid <= 1'b1;
        ALUResult <= launch_result;
        Zero      <= is_zero(launch_result);
      end
    end else begin
      case (state)
        ST_MUL, ST_DIV: begin
          if (iter_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            ALUResult <= iter_result;
            Zero      <= is_zero(iter_result);
          end else if (!iter_busy) begin
            // Iterator idle while we wait on it: recover rather than hang.
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            Zero      <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            Zero      <= 1'b0;
          end
        end
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          Zero      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (DATA_WIDTH=32).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_alu_mc;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int lat;
  logic ready_seen;
  logic stable_ok;
  logic valid_seen;

  alu_mc #(
    .DATA_WIDTH(32),
    .OPCODE_LENGTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Operation (Operation),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, let it be accepted, then wait (bounded) for out_valid.
  // lat counts edges from the accept edge up to the first cycle with
  // out_valid=1 (1 = single-cycle). ready_seen flags in_ready=1 while waiting.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    tick();
    in_valid   = 1'b0;
    lat        = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 60) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    SrcA = 32'h0; SrcB = 32'h0; Operation = 4'h0;
    repeat (2) tick();
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_result",    ALUResult,          32'h0);
    check("rst_zero",      {31'h0, Zero},      32'h0);
    reset = 1'b0;
    #1;
    check("rst_in_ready",  {31'h0, in_ready},  32'h1);

    // Single-cycle ops
    run_op(4'h2, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_lat",    lat,               32'd1);
    check("add_result", ALUResult,         32'h8000_0000);
    check("add_zero",   {31'h0, Zero},     32'h0);
    run_op(4'h6, 32'd5, 32'd5);
    check("sub_result", ALUResult,         32'h0);
    check("sub_zero",   {31'h0, Zero},     32'h1);
    run_op(4'h4, 32'hFFFF_FFFF, 32'h0000_0001);
    check("slt_result", ALUResult,         32'h1);
    run_op(4'h5, 32'hFFFF_FFFF, 32'h0000_0001);
    check("sltu_result", ALUResult,        32'h0);
    run_op(4'h7, 32'h0000_0001, 32'h0000_003F);
    check("sll_result", ALUResult,         32'h8000_0000);
    run_op(4'h8, 32'h1234_5678, 32'h1234_5678);
    check("eq_result",  ALUResult,         32'h1);
    run_op(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("op_f_result", ALUResult,        32'h0);
    check("op_f_zero",  {31'h0, Zero},     32'h1);

    // Iterative multiply
    run_op(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_lat",     lat,                 32'd33);
    check("mul_result",  ALUResult,           32'h0000_0001);
    check("mul_ready",   {31'h0, ready_seen}, 32'h0);
    run_op(4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhu_lat",   lat,                 32'd33);
    check("mulhu_result", ALUResult,          32'hFFFF_FFFE);

    // Iterative divide and divide by zero
    run_op(4'hD, 32'd100, 32'd7);
    check("divu_lat",    lat,       32'd33);
    check("divu_result", ALUResult, 32'd14);
    run_op(4'hE, 32'd100, 32'd7);
    check("remu_result", ALUResult, 32'd2);
    run_op(4'hD, 32'd5, 32'd0);
    check("divu0_lat",    lat,       32'd1);
    check("divu0_result", ALUResult, 32'hFFFF_FFFF);
    run_op(4'hE, 32'd5, 32'd0);
    check("remu0_lat",    lat,       32'd1);
    check("remu0_result", ALUResult, 32'd5);

    // Backpressure: hold result 5 cycles while a new op waits
    tick();
    out_ready = 1'b0;
    run_op(4'h0, 32'h0000_F0F0, 32'h0000_FF00);
    check("bp_and_result", ALUResult, 32'h0000_F000);
    Operation = 4'h3; SrcA = 32'h0000_000F; SrcB = 32'h0000_00FF; in_valid = 1'b1;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ALUResult !== 32'h0000_F000 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    check("bp_stable", {31'h0, stable_ok}, 32'h1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_b2b_valid",  {31'h0, out_valid}, 32'h1);
    check("bp_b2b_result", ALUResult,          32'h0000_00F0);

    // Async reset mid-multiply
    Operation = 4'hB; SrcA = 32'd3; SrcB = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 32'h0);
    check("arst_result",    ALUResult,          32'h0);
    check("arst_in_ready",  {31'h0, in_ready},  32'h1);
    tick();
    reset = 1'b0;
    run_op(4'hA, 32'h8000_0000, 32'd4);
    check("sra_lat",    lat,       32'd1);
    check("sra_result", ALUResult, 32'hF800_0000);
    run_op(4'h9, 32'h8000_0000, 32'd4);
    check("srl_result", ALUResult, 32'h0800_0000);
    tick();

    // Flush during divide; op presented with flush is not accepted
    Operation = 4'hD; SrcA = 32'd1000; SrcB = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    Operation = 4'h2; SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'h0, out_valid}, 32'h0);
    check("flush_in_ready",  {31'h0, in_ready},  32'h1);
    valid_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) valid_seen = 1'b1;
    end
    check("flush_never_valid", {31'h0, valid_seen}, 32'h0);

    // Flush in IDLE with a same-cycle request
    flush = 1'b1;
    Operation = 4'h2; SrcA = 32'd2; SrcB = 32'd2; in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle_valid", {31'h0, out_valid}, 32'h0);
    tick();
    check("flush_idle_later", {31'h0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
